// File: rtl/unpack_arbiter.sv
// rtl/unpack_arbiter.sv - enc/dec arbiter for the shared state-unpack unit; optional watchdog under UNPACK_ARB_TIMEOUT_EN
module unpack_arbiter #(
    parameter int                WORDS    = 64,
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] ENC_BASE = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] DEC_BASE = ADDR_W'(64),
    parameter int                TMO_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_req,
    input  logic              dec_req,
    output logic              enc_grant,
    output logic              dec_grant,
    output logic              enc_done,
    output logic              dec_done,
    output logic              unp_enable,
    output logic              unp_mux,
    input  logic              unp_done,
    input  logic              unp_outready,
    input  logic [5:0]        unp_wad,
    input  logic [127:0]      unp_wdata1,
    input  logic [127:0]      unp_wdata2,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [127:0]      bram_wdata1,
    output logic [127:0]      bram_wdata2,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;       // 0 enc, 1 dec
    logic   last_q, last_d;         // winner of the previous job
    logic   err_q, err_d;
    // 7 bits so a full job of 64 strobes does not alias to 0
    logic [6:0] wcnt_q, wcnt_d;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [127:0]      wdata1_q, wdata2_q;
    logic              strobe;

`ifdef UNPACK_ARB_TIMEOUT_EN
    logic [12:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^13'(TMO_CYC);
`endif

    assign strobe = (state_q == RUN) && unp_outready;

    // State and job bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
`ifdef UNPACK_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
`ifdef UNPACK_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state: arbitration, strobe counting and job completion
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
`ifdef UNPACK_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (enc_req || dec_req) begin
                    // on a tie the requester that did not win last goes next
                    owner_d = (enc_req && dec_req) ? ~last_q : dec_req;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                state_d = RUN;
`ifdef UNPACK_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            RUN: begin
                if (unp_outready) begin
                    wcnt_d = wcnt_q + 7'd1;
                end
                if (unp_done) begin
                    state_d = FIN;
                end
`ifdef UNPACK_ARB_TIMEOUT_EN
                else if (tmo_q == 13'(TMO_CYC - 1)) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 13'd1;
                end
`endif
            end
            FIN: begin
                if (wcnt_q != 7'(WORDS)) begin
                    err_d = 1'b1;
                end
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One-cycle retiming of the unpack write stream into the BRAM port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else begin
            we_q <= strobe;
            if (strobe) begin
                waddr_q  <= (owner_q ? DEC_BASE : ENC_BASE) + ADDR_W'(unp_wad);
                wdata1_q <= unp_wdata1;
                wdata2_q <= owner_q ? unp_wdata2 : 128'd0;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign enc_grant   = busy && !owner_q;
    assign dec_grant   = busy && owner_q;
    assign enc_done    = (state_q == FIN) && !owner_q;
    assign dec_done    = (state_q == FIN) && owner_q;
    assign unp_enable  = (state_q == START);
    assign unp_mux     = (state_q == START) && owner_q;
    assign err         = err_q;
    assign bram_we     = we_q;
    assign bram_waddr  = waddr_q;
    assign bram_wdata1 = wdata1_q;
    assign bram_wdata2 = wdata2_q;

endmodule
